// File: rtl/rx_drain_ctrl.sv
// UART receive drain: acknowledges received bytes into a small FIFO
// and counts framing/overrun error events in saturating counters.
module rx_drain_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          data_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          framing_error,
  input  logic                          overrun_error,
  output logic                          data_read,
  input  logic                          pop,
  output logic [7:0]                    pop_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          clr_cnt,
  output logic [CNT_WIDTH-1:0]          frame_err_cnt,
  output logic [CNT_WIDTH-1:0]          overrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SETTLE
  } state_e;

  state_e               state_q, state_d;
  logic                 data_read_q, data_read_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic [CNT_WIDTH-1:0] fe_cnt_q, fe_cnt_d;
  logic [CNT_WIDTH-1:0] ov_cnt_q, ov_cnt_d;
  logic [7:0]           mem [FIFO_DEPTH];

  logic push;
  logic do_pop;
  logic full;
  logic empty;
  logic fe_evt;
  logic ov_evt;

  function automatic logic [CNT_WIDTH-1:0] next_cnt(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 evt,
    input logic                 clr
  );
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : cnt;
    if (evt && base != CNT_MAX)
      return base + 1'b1;
    return base;
  endfunction

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign push   = (state_q == IDLE) && data_ready && !full;
  assign do_pop = pop && !empty;
  assign fe_evt = framing_error && !fe_q;
  assign ov_evt = overrun_error && !ov_q;

  always_comb begin
    state_d     = state_q;
    data_read_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE:    if (push) state_d = ACK;
      ACK:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_read_d = (state_d == ACK);
    if (push)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    fe_d     = framing_error;
    ov_d     = overrun_error;
    fe_cnt_d = next_cnt(fe_cnt_q, fe_evt, clr_cnt);
    ov_cnt_d = next_cnt(ov_cnt_q, ov_evt, clr_cnt);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      data_read_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fe_q        <= 1'b0;
      ov_q        <= 1'b0;
      fe_cnt_q    <= '0;
      ov_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      data_read_q <= data_read_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fe_q        <= fe_d;
      ov_q        <= ov_d;
      fe_cnt_q    <= fe_cnt_d;
      ov_cnt_q    <= ov_cnt_d;
    end
  end

  // Storage survives reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= rx_data;
  end

  assign data_read     = data_read_q;
  assign pop_data      = mem[rd_ptr_q];
  assign fifo_empty    = empty;
  assign fifo_full     = full;
  assign fifo_count    = count_q;
  assign frame_err_cnt = fe_cnt_q;
  assign overrun_cnt   = ov_cnt_q;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Scoreboard bench for rx_drain_ctrl: expected bytes queued at send,
// a monitor compares pop_data on every effective pop.
module tb_rx_drain_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       framing_error = 1'b0;
  logic       overrun_error = 1'b0;
  logic       data_read;
  logic       pop = 1'b0;
  logic [7:0] pop_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       clr_cnt = 1'b0;
  logic [7:0] frame_err_cnt;
  logic [7:0] overrun_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  rx_drain_ctrl #(.FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .data_ready(data_ready), .rx_data(rx_data),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .data_read(data_read), .pop(pop), .pop_data(pop_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .clr_cnt(clr_cnt),
    .frame_err_cnt(frame_err_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every effective pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (n_rst && pop && !fifo_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected none", pop_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (pop_data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", pop_data, e);
        end
      end
    end
  end

  // Present a byte, wait for the acknowledge, check latency and width.
  task automatic send(input logic [7:0] b, input int lat);
    int n;
    bit seen;
    tick();
    exp_q.push_back(b);
    data_ready = 1'b1;
    rx_data    = b;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (data_read) seen = 1;
    end
    if (!seen) begin
      chk("ack_timeout", 0, 1);
    end else if (lat > 0) begin
      chk("ack_latency", n, lat);
    end
    tick();
    data_ready = 1'b0;
    @(negedge clk);
    chk("ack_width", int'(data_read), 0);
  endtask

  task automatic do_pop();
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;
    #12;
    @(negedge clk);
    chk("rst_data_read", int'(data_read), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_fe_cnt", int'(frame_err_cnt), 0);
    chk("rst_ov_cnt", int'(overrun_cnt), 0);
    n_rst = 1'b1;

    send(8'hA5, 2);
    chk("single_count", int'(fifo_count), 1);
    chk("single_data", int'(pop_data), 8'hA5);
    do_pop();
    chk("single_empty", int'(fifo_empty), 1);
    chk("single_count0", int'(fifo_count), 0);

    for (int i = 1; i <= 4; i++) send(8'(i), 2);
    chk("fill_full", int'(fifo_full), 1);
    chk("fill_count", int'(fifo_count), 4);
    tick();
    exp_q.push_back(8'h05);
    data_ready = 1'b1;
    rx_data    = 8'h05;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_read) seen = 1;
    end
    chk("stall_no_ack", int'(seen), 0);
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    seen = 0;
    n = 0;
    while (!seen && n < 3) begin
      @(negedge clk);
      n++;
      if (data_read) seen = 1;
    end
    chk("stall_ack_after_pop", int'(seen), 1);
    tick();
    data_ready = 1'b0;
    @(negedge clk);
    chk("stall_count", int'(fifo_count), 4);
    for (int i = 0; i < 4; i++) do_pop();
    chk("stall_drained", int'(fifo_empty), 1);

    for (int i = 0; i < 10; i += 2) begin
      send(8'(8'h10 + i), 2);
      send(8'(8'h11 + i), 2);
      chk("wrap_count", int'(fifo_count), 2);
      do_pop();
      do_pop();
    end
    chk("wrap_empty", int'(fifo_empty), 1);
    do_pop();
    chk("empty_pop_count", int'(fifo_count), 0);
    chk("empty_pop_flag", int'(fifo_empty), 1);

    send(8'h21, 2);
    send(8'h22, 2);
    tick();
    exp_q.push_back(8'h55);
    data_ready = 1'b1;
    rx_data    = 8'h55;
    pop        = 1'b1;
    tick();
    pop = 1'b0;
    @(negedge clk);
    chk("simul_ack", int'(data_read), 1);
    chk("simul_count", int'(fifo_count), 2);
    chk("simul_head", int'(pop_data), 8'h22);
    tick();
    data_ready = 1'b0;
    do_pop();
    do_pop();
    chk("simul_empty", int'(fifo_empty), 1);

    tick();
    framing_error = 1'b1;
    @(negedge clk);
    chk("fe_not_yet", int'(frame_err_cnt), 0);
    tick();
    framing_error = 1'b0;
    @(negedge clk);
    chk("fe_first", int'(frame_err_cnt), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      framing_error = 1'b1;
      tick();
      framing_error = 1'b0;
    end
    tick();
    framing_error = 1'b1;
    repeat (20) tick();
    framing_error = 1'b0;
    @(negedge clk);
    chk("fe_held", int'(frame_err_cnt), 4);
    for (int i = 0; i < 300; i++) begin
      tick();
      overrun_error = 1'b1;
      tick();
      overrun_error = 1'b0;
    end
    @(negedge clk);
    chk("ov_saturate", int'(overrun_cnt), 255);
    tick();
    clr_cnt       = 1'b1;
    framing_error = 1'b1;
    tick();
    clr_cnt       = 1'b0;
    framing_error = 1'b0;
    @(negedge clk);
    chk("clr_fe", int'(frame_err_cnt), 1);
    chk("clr_ov", int'(overrun_cnt), 0);

    tick();
    exp_q.push_back(8'h99);
    data_ready = 1'b1;
    rx_data    = 8'h99;
    seen = 0;
    n = 0;
    while (!seen && n < 5) begin
      @(negedge clk);
      n++;
      if (data_read) seen = 1;
    end
    chk("rst_mid_ack", int'(seen), 1);
    #1;
    n_rst      = 1'b0;
    data_ready = 1'b0;
    #1;
    chk("rst_mid_data_read", int'(data_read), 0);
    chk("rst_mid_count", int'(fifo_count), 0);
    chk("rst_mid_fe", int'(frame_err_cnt), 0);
    chk("rst_mid_ov", int'(overrun_cnt), 0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    send(8'h3C, 2);
    chk("post_rst_count", int'(fifo_count), 1);
    do_pop();
    chk("post_rst_empty", int'(fifo_empty), 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
